// File: rtl/dcache_nway.sv
// N-way set-associative, write-back, write-allocate data cache with true-LRU replacement.
// Define DCACHE_HITCNT_EN to write the hit counter to HITCNT_ADDR after the halt flush.
module dcache_nway #(
  parameter int unsigned SETS          = 8,
  parameter int unsigned WAYS          = 2,
  parameter int unsigned WORDS_PER_BLK = 2,
  parameter logic [31:0] HITCNT_ADDR   = 32'h00003100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);
  localparam int unsigned BW  = $clog2(WORDS_PER_BLK);
  localparam int unsigned IW  = $clog2(SETS);
  localparam int unsigned TW  = 30 - BW - IW;
  localparam int unsigned BWS = (BW > 0) ? BW : 1;
  localparam int unsigned WWS = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [BWS-1:0] LAST_WORD = BWS'(WORDS_PER_BLK - 1);
  localparam logic [WWS-1:0] LAST_WAY  = WWS'(WAYS - 1);
  localparam logic [IW-1:0]  LAST_SET  = IW'(SETS - 1);

`ifdef DCACHE_HITCNT_EN
  typedef enum logic [2:0] {IDLE, WB, FILL, HALT, HITCNT, FLUSHED} state_e;
  logic [31:0] hitcnt_q;
  logic        miss_pending_q;
`else
  typedef enum logic [2:0] {IDLE, WB, FILL, HALT, FLUSHED} state_e;
  logic unused_hitcnt_addr;
  assign unused_hitcnt_addr = ^HITCNT_ADDR;
`endif

  logic [31:0]    data_q  [SETS][WAYS][WORDS_PER_BLK];
  logic [TW-1:0]  tag_q   [SETS][WAYS];
  logic [WWS-1:0] age_q   [SETS][WAYS];
  logic           valid_q [SETS][WAYS];
  logic           dirty_q [SETS][WAYS];

  state_e         state_q, state_d;
  logic [BWS-1:0] word_q, word_d;
  logic [WWS-1:0] victim_q, victim_d, hway_q, hway_d;
  logic [IW-1:0]  ridx_q, ridx_d, hset_q, hset_d;
  logic [TW-1:0]  rtag_q, rtag_d;

  logic [BWS-1:0] req_off;
  logic [IW-1:0]  req_idx;
  logic [TW-1:0]  req_tag;
  logic           req_v, hit, found, halt_dirty;
  logic [WWS-1:0] hit_way, vict_way;
  logic           hit_wr, lru_upd, fill_wr, fill_last, halt_inval;

  assign req_off = BWS'((dmemaddr >> 2) & 32'(WORDS_PER_BLK - 1));
  assign req_idx = IW'(dmemaddr >> (2 + BW));
  assign req_tag = TW'(dmemaddr >> (2 + BW + IW));
  assign req_v   = dmemREN ^ dmemWEN;

  function automatic logic [31:0] blk_addr(input logic [TW-1:0] t, input logic [IW-1:0] s,
                                           input logic [BWS-1:0] w);
    return ((32'(t) << (IW + BW)) | (32'(s) << BW) | 32'(w)) << 2;
  endfunction

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    found    = 1'b0;
    vict_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WWS'(w);
      end
      if (!found && !valid_q[req_idx][w]) begin
        found    = 1'b1;
        vict_way = WWS'(w);
      end
    end
    // With no free way, the oldest way (age WAYS-1) is evicted.
    if (!found)
      for (int unsigned w = 0; w < WAYS; w++)
        if (age_q[req_idx][w] == LAST_WAY) vict_way = WWS'(w);
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    victim_d   = victim_q;
    ridx_d     = ridx_q;
    rtag_d     = rtag_q;
    hset_d     = hset_q;
    hway_d     = hway_q;
    dhit       = 1'b0;
    dmemload   = '0;
    flushed    = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    daddr      = '0;
    dstore     = '0;
    hit_wr     = 1'b0;
    lru_upd    = 1'b0;
    fill_wr    = 1'b0;
    fill_last  = 1'b0;
    halt_inval = 1'b0;
    halt_dirty = valid_q[hset_q][hway_q] && dirty_q[hset_q][hway_q];
    unique case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = HALT;
          word_d  = '0;
          hset_d  = '0;
          hway_d  = '0;
        end else if (req_v) begin
          if (hit) begin
            dhit    = 1'b1;
            lru_upd = 1'b1;
            if (dmemREN) dmemload = data_q[req_idx][hit_way][req_off];
            else         hit_wr   = 1'b1;
          end else begin
            ridx_d   = req_idx;
            rtag_d   = req_tag;
            victim_d = vict_way;
            word_d   = '0;
            state_d  = (valid_q[req_idx][vict_way] && dirty_q[req_idx][vict_way]) ? WB : FILL;
          end
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = blk_addr(tag_q[ridx_q][victim_q], ridx_q, word_q);
        dstore = data_q[ridx_q][victim_q][word_q];
        if (!dwait) begin
          word_d = word_q + 1'b1;
          if (word_q == LAST_WORD) begin
            word_d  = '0;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        dREN  = 1'b1;
        daddr = blk_addr(rtag_q, ridx_q, word_q);
        if (!dwait) begin
          fill_wr = 1'b1;
          word_d  = word_q + 1'b1;
          if (word_q == LAST_WORD) begin
            fill_last = 1'b1;
            word_d    = '0;
            state_d   = IDLE;
          end
        end
      end
      HALT: begin
        if (halt_dirty) begin
          dWEN   = 1'b1;
          daddr  = blk_addr(tag_q[hset_q][hway_q], hset_q, word_q);
          dstore = data_q[hset_q][hway_q][word_q];
        end
        // Clean/invalid lines still step one word per cycle, keeping the walk uniform.
        if (!halt_dirty || !dwait) begin
          word_d = word_q + 1'b1;
          if (word_q == LAST_WORD) begin
            word_d     = '0;
            halt_inval = 1'b1;
            hway_d     = hway_q + 1'b1;
            if (hway_q == LAST_WAY) begin
              hway_d = '0;
              hset_d = hset_q + 1'b1;
              if (hset_q == LAST_SET) begin
                hset_d = '0;
`ifdef DCACHE_HITCNT_EN
                state_d = HITCNT;
`else
                state_d = FLUSHED;
`endif
              end
            end
          end
        end
      end
`ifdef DCACHE_HITCNT_EN
      HITCNT: begin
        dWEN   = 1'b1;
        daddr  = HITCNT_ADDR;
        dstore = hitcnt_q;
        if (!dwait) state_d = FLUSHED;
      end
`endif
      FLUSHED: flushed = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      word_q   <= '0;
      victim_q <= '0;
      ridx_q   <= '0;
      rtag_q   <= '0;
      hset_q   <= '0;
      hway_q   <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      victim_q <= victim_d;
      ridx_q   <= ridx_d;
      rtag_q   <= rtag_d;
      hset_q   <= hset_d;
      hway_q   <= hway_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned s = 0; s < SETS; s++)
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          age_q[s][w]   <= WWS'(w);
        end
    end else begin
      if (lru_upd)
        for (int unsigned w = 0; w < WAYS; w++)
          if (WWS'(w) == hit_way) age_q[req_idx][w] <= '0;
          else if (age_q[req_idx][w] < age_q[req_idx][hit_way])
            age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
      if (hit_wr) dirty_q[req_idx][hit_way] <= 1'b1;
      if (fill_last) begin
        valid_q[ridx_q][victim_q] <= 1'b1;
        dirty_q[ridx_q][victim_q] <= 1'b0;
        tag_q[ridx_q][victim_q]   <= rtag_q;
      end
      if (halt_inval) begin
        valid_q[hset_q][hway_q] <= 1'b0;
        dirty_q[hset_q][hway_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (hit_wr)       data_q[req_idx][hit_way][req_off] <= dmemstore;
    else if (fill_wr) data_q[ridx_q][victim_q][word_q]  <= dload;
  end

`ifdef DCACHE_HITCNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hitcnt_q       <= '0;
      miss_pending_q <= 1'b0;
    end else if (fill_last) begin
      miss_pending_q <= 1'b1;
    end else if (dhit) begin
      // The first hit after a fill is the retried miss, not a real hit.
      if (miss_pending_q) miss_pending_q <= 1'b0;
      else                hitcnt_q       <= hitcnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_nway.sv
// Directed self-checking bench for dcache_nway (default geometry plus a 16-set 4-way instance).
module tb_dcache_nway;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        nRST, halt, dmemREN, dmemWEN, dhit, flushed, dREN, dWEN, dwait;
  logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload;
  logic [1:0]  wcnt;
  int          tests, fails;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_wr[$];

  logic        nRST2, halt2, d2ren, d2wen, d2hit, d2flushed, d2REN, d2WEN, d2dwait;
  logic [31:0] d2addr, d2store, d2load, d2daddr, d2dstore, d2dload;

  dcache_nway #(.SETS(8), .WAYS(2), .WORDS_PER_BLK(2), .HITCNT_ADDR(32'h00003100)) u_dut (
    .CLK(CLK), .nRST(nRST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
    .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait));

  dcache_nway #(.SETS(16), .WAYS(4), .WORDS_PER_BLK(2), .HITCNT_ADDR(32'h00003100)) u_dut4 (
    .CLK(CLK), .nRST(nRST2), .halt(halt2), .dmemREN(d2ren), .dmemWEN(d2wen),
    .dmemaddr(d2addr), .dmemstore(d2store), .dhit(d2hit), .dmemload(d2load),
    .flushed(d2flushed), .dREN(d2REN), .dWEN(d2WEN), .daddr(d2daddr), .dstore(d2dstore),
    .dload(d2dload), .dwait(d2dwait));

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hA5A50000;
  endfunction

  // Memory: every word costs two stall cycles then completes; completed transfers are logged.
  assign dload   = pat(daddr);
  assign dwait   = (wcnt != 2'd2);
  assign d2dload = d2daddr ^ 32'h0F0F0000;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) wcnt <= 2'd0;
    else if (dREN || dWEN) begin
      if (!dwait) begin
        log_wr.push_back(dWEN);
        log_addr.push_back(daddr);
        log_data.push_back(dWEN ? dstore : dload);
        wcnt <= 2'd0;
      end else wcnt <= wcnt + 2'd1;
    end else wcnt <= 2'd0;
  end

  task automatic clear_log();
    log_wr.delete(); log_addr.delete(); log_data.delete();
  endtask

  task automatic do_reset();
    nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    @(posedge CLK); #1;
    clear_log();
  endtask

  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int cyc, output logic [31:0] rd, output logic ok);
    dmemREN = r; dmemWEN = w; dmemaddr = a; dmemstore = d;
    cyc = 0; rd = '0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (dhit) begin ok = 1'b1; rd = dmemload; break; end
      cyc++;
    end
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    tests++;
    if ({dhit, flushed, dREN, dWEN} !== 4'b0 || daddr !== 32'h0 || dstore !== 32'h0 || dmemload !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: dhit=%b flushed=%b dREN=%b dWEN=%b daddr=%h dstore=%h dmemload=%h, all required 0",
               dhit, flushed, dREN, dWEN, daddr, dstore, dmemload);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_cold_read();
    int cyc; logic [31:0] rd; logic ok; logic bad;
    clear_log();
    access(1'b1, 1'b0, 32'h48, 32'h0, cyc, rd, ok);
    tests++;
    if (!ok || cyc != 7) begin fails++; $display("FAIL cold_latency: hit=%b cycles=%0d, required hit after 7", ok, cyc); end
    tests++;
    if (rd !== pat(32'h48)) begin fails++; $display("FAIL cold_rdata: got %h required %h", rd, pat(32'h48)); end
    tests++;
    bad = (log_addr.size() != 2);
    if (!bad) bad = log_wr[0] || log_wr[1] || log_addr[0] !== 32'h48 || log_addr[1] !== 32'h4C;
    if (bad) begin fails++; $display("FAIL cold_fill_reads: %0d transfers, required reads of 48 then 4C", log_addr.size()); end
  endtask

  task automatic test_write_hit();
    int cyc; logic [31:0] rd; logic ok;
    clear_log();
    access(1'b0, 1'b1, 32'h48, 32'hDEADBEEF, cyc, rd, ok);
    tests++;
    if (!ok || cyc != 0) begin fails++; $display("FAIL write_hit_latency: hit=%b cycles=%0d, required 0", ok, cyc); end
    access(1'b1, 1'b0, 32'h4C, 32'h0, cyc, rd, ok);
    tests++;
    if (!ok || cyc != 0 || rd !== pat(32'h4C)) begin
      fails++; $display("FAIL read_hit_4C: cycles=%0d data=%h, required 0 and %h", cyc, rd, pat(32'h4C));
    end
    access(1'b1, 1'b0, 32'h48, 32'h0, cyc, rd, ok);
    tests++;
    if (!ok || cyc != 0 || rd !== 32'hDEADBEEF) begin
      fails++; $display("FAIL read_back_48: cycles=%0d data=%h, required 0 and deadbeef", cyc, rd);
    end
    tests++;
    if (log_addr.size() != 0) begin fails++; $display("FAIL hit_no_traffic: %0d transfers, required 0", log_addr.size()); end
  endtask

  task automatic test_both_high();
    int cyc; logic [31:0] rd; logic ok; logic bad;
    clear_log();
    dmemREN = 1'b1; dmemWEN = 1'b1; dmemaddr = 32'h48; dmemstore = 32'h0BAD0BAD;
    bad = 1'b0;
    repeat (3) begin @(negedge CLK); if (dhit) bad = 1'b1; end
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
    tests++;
    if (bad) begin fails++; $display("FAIL both_high_dhit: dhit seen, required 0"); end
    access(1'b1, 1'b0, 32'h48, 32'h0, cyc, rd, ok);
    tests++;
    if (!ok || rd !== 32'hDEADBEEF || log_addr.size() != 0) begin
      fails++; $display("FAIL both_high_state: data=%h transfers=%0d, required deadbeef and 0", rd, log_addr.size());
    end
  endtask

  task automatic test_conflict();
    int cyc; logic [31:0] rd; logic ok; logic bad;
    logic [31:0] ea[4];
    logic [31:0] ed[4];
    logic        ew[4];
    ea = '{32'h88, 32'h8C, 32'hC8, 32'hCC};
    ed = '{32'h12345678, pat(32'h8C), pat(32'hC8), pat(32'hCC)};
    ew = '{1'b1, 1'b1, 1'b0, 1'b0};
    access(1'b0, 1'b1, 32'h88, 32'h12345678, cyc, rd, ok);
    tests++;
    if (!ok || cyc != 7) begin fails++; $display("FAIL tagB_fill: hit=%b cycles=%0d, required 7", ok, cyc); end
    access(1'b1, 1'b0, 32'h48, 32'h0, cyc, rd, ok);
    clear_log();
    access(1'b1, 1'b0, 32'hC8, 32'h0, cyc, rd, ok);
    tests++;
    if (!ok || cyc != 13 || rd !== pat(32'hC8)) begin
      fails++; $display("FAIL tagC_miss: cycles=%0d data=%h, required 13 and %h", cyc, rd, pat(32'hC8));
    end
    tests++;
    bad = (log_addr.size() != 4);
    for (int i = 0; i < 4 && !bad; i++)
      if (log_wr[i] !== ew[i] || log_addr[i] !== ea[i] || log_data[i] !== ed[i]) bad = 1'b1;
    if (bad) begin
      fails++;
      $display("FAIL lru_victim_wb: %0d transfers (first addr %h), required WB 88,8C then fill C8,CC",
               log_addr.size(), (log_addr.size() > 0) ? log_addr[0] : 32'h0);
    end
    clear_log();
    access(1'b1, 1'b0, 32'h4C, 32'h0, cyc, rd, ok);
    tests++;
    if (!ok || cyc != 0 || rd !== pat(32'h4C)) begin
      fails++; $display("FAIL tagA_kept: cycles=%0d data=%h, required 0 and %h", cyc, rd, pat(32'h4C));
    end
  endtask

  task automatic test_halt();
    int cyc; logic [31:0] rd; logic ok; logic bad; logic seen; logic early; int n;
    logic [31:0] ea[5];
    logic [31:0] ed[5];
    ea = '{32'h00, 32'h04, 32'h178, 32'h17C, 32'h3100};
    ed = '{32'h11112222, pat(32'h04), pat(32'h178), 32'h33334444, 32'd2};
`ifdef DCACHE_HITCNT_EN
    n = 5;
`else
    n = 4;
`endif
    do_reset();
    access(1'b0, 1'b1, 32'h00, 32'h11112222, cyc, rd, ok);
    access(1'b0, 1'b1, 32'h17C, 32'h33334444, cyc, rd, ok);
    access(1'b1, 1'b0, 32'h00, 32'h0, cyc, rd, ok);
    dmemREN = 1'b1; dmemWEN = 1'b1; dmemaddr = 32'h00;
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
    access(1'b1, 1'b0, 32'h04, 32'h0, cyc, rd, ok);
    clear_log();
    halt = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h00;
    @(negedge CLK);
    tests++;
    if (dhit !== 1'b0) begin fails++; $display("FAIL halt_priority: dhit=%b, required 0", dhit); end
    @(posedge CLK); #1;
    dmemREN = 1'b0;
    seen = 1'b0; early = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (log_addr.size() >= n) begin seen = 1'b1; break; end
      if (flushed) early = 1'b1;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL halt_timeout: %0d transfers, required %0d", log_addr.size(), n); end
    tests++;
    if (early) begin fails++; $display("FAIL flushed_early: flushed=1 before the last transfer, required 0"); end
`ifdef DCACHE_HITCNT_EN
    tests++;
    if (flushed !== 1'b1) begin fails++; $display("FAIL flushed_timing: flushed=%b after counter write, required 1", flushed); end
`else
    tests++;
    if (flushed !== 1'b0) begin fails++; $display("FAIL flushed_timing: flushed=%b during last-set walk, required 0", flushed); end
    repeat (2) @(negedge CLK);
    tests++;
    if (flushed !== 1'b1) begin fails++; $display("FAIL flushed_after_walk: flushed=%b, required 1", flushed); end
`endif
    repeat (4) @(negedge CLK);
    tests++;
    bad = (log_addr.size() != n);
    for (int i = 0; i < n && !bad; i++)
      if (log_wr[i] !== 1'b1 || log_addr[i] !== ea[i] || log_data[i] !== ed[i]) bad = 1'b1;
    if (bad) begin
      fails++;
      $display("FAIL flush_writes: %0d transfers (last addr %h data %h), required %0d",
               log_addr.size(), (log_addr.size() > 0) ? log_addr[log_addr.size()-1] : 32'h0,
               (log_data.size() > 0) ? log_data[log_data.size()-1] : 32'h0, n);
    end
    tests++;
    if (flushed !== 1'b1 || dWEN !== 1'b0 || dREN !== 1'b0) begin
      fails++; $display("FAIL flushed_hold: flushed=%b dREN=%b dWEN=%b, required 1 0 0", flushed, dREN, dWEN);
    end
    halt = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h00;
    @(negedge CLK);
    tests++;
    if (dhit !== 1'b0 || flushed !== 1'b1) begin
      fails++; $display("FAIL no_service_after_halt: dhit=%b flushed=%b, required 0 1", dhit, flushed);
    end
    @(posedge CLK); #1;
    dmemREN = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    logic ok;
    d2dwait = 1'b1;
    @(posedge CLK); #1 nRST2 = 1'b1;
    @(posedge CLK); #1;
    d2ren = 1'b1; d2addr = 32'h123C;
    @(negedge CLK);
    tests++;
    if (d2hit !== 1'b0) begin fails++; $display("FAIL w4_cold_miss: dhit=%b, required 0", d2hit); end
    repeat (3) @(negedge CLK);
    tests++;
    if (d2REN !== 1'b1 || d2daddr !== 32'h1238) begin
      fails++; $display("FAIL w4_fill_stall: dREN=%b daddr=%h, required 1 and 00001238", d2REN, d2daddr);
    end
    #2 nRST2 = 1'b0;
    #1;
    tests++;
    if (d2REN !== 1'b0 || d2daddr !== 32'h0) begin
      fails++; $display("FAIL w4_async_reset: dREN=%b daddr=%h, required 0 and 0", d2REN, d2daddr);
    end
    @(posedge CLK); #1 nRST2 = 1'b1;
    d2dwait = 1'b0;
    @(negedge CLK);
    tests++;
    if (d2hit !== 1'b0) begin fails++; $display("FAIL w4_remiss: dhit=%b after reset, required 0", d2hit); end
    @(negedge CLK);
    tests++;
    if (d2REN !== 1'b1 || d2daddr !== 32'h1238) begin
      fails++; $display("FAIL w4_refill: dREN=%b daddr=%h, required 1 and 00001238", d2REN, d2daddr);
    end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (d2hit) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok || d2load !== (32'h123C ^ 32'h0F0F0000)) begin
      fails++; $display("FAIL w4_refill_hit: hit=%b data=%h, required 1 and %h", ok, d2load, 32'h123C ^ 32'h0F0F0000);
    end
    @(posedge CLK); #1;
    d2ren = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
    nRST2 = 1'b0; halt2 = 1'b0; d2ren = 1'b0; d2wen = 1'b0; d2addr = '0; d2store = '0; d2dwait = 1'b1;
    test_reset();
    test_cold_read();
    test_write_hit();
    test_both_high();
    test_conflict();
    test_halt();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
